// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    function automatic logic is_aligned(
        input logic [31:0] addr
    );
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register with load, hold and flush controls.
module if_id_register
    import mips_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        flush_en,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    // Flush wins over load; pc fields survive a flush.
    always_comb begin
        valid_d    = valid_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        priority case (1'b1)
            flush_en: begin
                valid_d = 1'b0;
                inst_d  = INST_NOP;
            end
            load_en: begin
                valid_d    = 1'b1;
                inst_d     = inst_i;
                pc_d       = pc_i;
                pc_plus4_d = pc_i + PC_STEP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            inst_q     <= INST_NOP;
            pc_q       <= 32'h0;
            pc_plus4_q <= PC_STEP;
        end else begin
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid_o    = valid_q;
    assign inst_o     = inst_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, redirect/fault FSM, fetch counter, IF/ID.
module instruction_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic [31:0]  count_q, count_d;
    logic         load_en;
    logic         flush_en;

    // Redirect beats the FAULT hold, which beats stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;
        load_en    = 1'b0;
        flush_en   = 1'b0;
        priority case (1'b1)
            redirect_valid: begin
                pc_d     = redirect_pc;
                flush_en = 1'b1;
                if (is_aligned(redirect_pc)) begin
                    state_d = RUN;
                    fault_d = 1'b0;
                end else begin
                    state_d    = FAULT;
                    fault_d    = 1'b1;
                    fault_pc_d = redirect_pc;
                end
            end
            (state_q == FAULT): ;
            stall: ;
            default: begin
                load_en = 1'b1;
                pc_d    = pc_q + PC_STEP;
                count_d = count_q + 32'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
            count_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    if_id_register u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .flush_en   (flush_en),
        .inst_i     (imem_data),
        .pc_i       (pc_q),
        .valid_o    (id_valid),
        .inst_o     (id_inst),
        .pc_o       (id_pc),
        .pc_plus4_o (id_pc_plus4)
    );

    assign imem_addr   = pc_q;
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic [31:0] a_addr, a_data;
    logic        a_valid, a_fault;
    logic [31:0] a_inst, a_pc, a_p4, a_fpc, a_cnt;

    logic        rst_b = 1'b1;
    logic [31:0] b_addr, b_data;
    logic        b_valid, b_fault;
    logic [31:0] b_inst, b_pc, b_p4, b_fpc, b_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a < 32'd16)
            return (a / 32'd4 + 32'd1) * 32'h11;
        return a ^ 32'hDEAD_0000;
    endfunction

    assign a_data = mem(a_addr);
    assign b_data = mem(b_addr);

    instruction_fetch #(.RESET_PC(32'h0)) u_a (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(rv), .redirect_pc(rpc),
        .imem_addr(a_addr), .imem_data(a_data),
        .id_valid(a_valid), .id_inst(a_inst),
        .id_pc(a_pc), .id_pc_plus4(a_p4),
        .fetch_fault(a_fault), .fault_pc(a_fpc),
        .fetch_count(a_cnt)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_b (
        .clk(clk), .rst(rst_b), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_addr(b_addr), .imem_data(b_data),
        .id_valid(b_valid), .id_inst(b_inst),
        .id_pc(b_pc), .id_pc_plus4(b_p4),
        .fetch_fault(b_fault), .fault_pc(b_fpc),
        .fetch_count(b_cnt)
    );

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] p4;
        logic        fault;
        logic [31:0] fpc;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    logic m_flt_st;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m.addr  = 32'h0;
        m.valid = 1'b0;
        m.inst  = 32'h0;
        m.pc    = 32'h0;
        m.p4    = 32'd4;
        m.fault = 1'b0;
        m.fpc   = 32'h0;
        m.cnt   = 32'h0;
        m_flt_st = 1'b0;
    endtask

    task automatic model_next(input logic r, input logic s,
                              input logic v, input logic [31:0] t);
        if (r) begin
            model_reset();
        end else if (v) begin
            m.addr  = t;
            m.valid = 1'b0;
            m.inst  = 32'h0;
            if (t[1:0] != 2'b00) begin
                m_flt_st = 1'b1;
                m.fault  = 1'b1;
                m.fpc    = t;
            end else begin
                m_flt_st = 1'b0;
                m.fault  = 1'b0;
            end
        end else if (!m_flt_st && !s) begin
            m.inst  = mem(m.addr);
            m.pc    = m.addr;
            m.p4    = m.addr + 32'd4;
            m.valid = 1'b1;
            m.addr  = m.addr + 32'd4;
            m.cnt   = m.cnt + 32'd1;
        end
    endtask

    task automatic step(input logic r, input logic s,
                        input logic v, input logic [31:0] t);
        exp_t e;
        rst = r;
        stall = s;
        rv = v;
        rpc = t;
        model_next(r, s, v, t);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("addr", a_addr, e.addr);
            chk("valid", {31'b0, a_valid}, {31'b0, e.valid});
            chk("inst", a_inst, e.inst);
            chk("id_pc", a_pc, e.pc);
            chk("p4", a_p4, e.p4);
            chk("fault", {31'b0, a_fault}, {31'b0, e.fault});
            chk("fpc", a_fpc, e.fpc);
            chk("cnt", a_cnt, e.cnt);
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 0, 0);
        chk("rst_addr", a_addr, 32'h0);
        chk("rst_p4", a_p4, 32'd4);

        repeat (3) step(0, 0, 0, 0);
        chk("f3_inst", a_inst, 32'h33);
        chk("f3_pc", a_pc, 32'd8);
        chk("f3_p4", a_p4, 32'd12);
        chk("f3_cnt", a_cnt, 32'd3);

        step(1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        chk("pre_st", a_inst, 32'h22);
        repeat (2) begin
            step(0, 1, 0, 0);
            chk("st_inst", a_inst, 32'h22);
            chk("st_addr", a_addr, 32'd8);
            chk("st_cnt", a_cnt, 32'd2);
        end
        step(0, 0, 0, 0);
        chk("st_rel", a_inst, 32'h33);

        step(0, 1, 1, 32'h40);
        chk("rd_addr", a_addr, 32'h40);
        chk("rd_valid", {31'b0, a_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("rd_pc", a_pc, 32'h40);
        chk("rd_v1", {31'b0, a_valid}, 32'd1);

        step(0, 0, 1, 32'h42);
        chk("flt", {31'b0, a_fault}, 32'd1);
        chk("flt_pc", a_fpc, 32'h42);
        for (int i = 0; i < 5; i++) begin
            step(0, i[0], 0, 0);
            chk("flt_v", {31'b0, a_valid}, 32'd0);
            chk("flt_cnt", a_cnt, 32'd4);
        end
        step(0, 0, 1, 32'h43);
        chk("flt_pc2", a_fpc, 32'h43);
        step(0, 0, 1, 32'h80);
        chk("flt_clr", {31'b0, a_fault}, 32'd0);
        step(0, 0, 0, 0);
        chk("f80_pc", a_pc, 32'h80);
        chk("f80_inst", a_inst, 32'hDEAD_0080);

        step(0, 0, 1, 32'h41);
        step(1, 0, 0, 0);
        chk("rf_flt", {31'b0, a_fault}, 32'd0);
        chk("rf_addr", a_addr, 32'h0);
        chk("rf_cnt", a_cnt, 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] t;
            logic v;
            t = {$urandom_range(0, 255), 2'b00} |
                (($urandom_range(0, 5) == 0) ?
                 32'($urandom_range(1, 3)) : 32'd0);
            v = ($urandom_range(0, 7) == 0);
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0), v, t);
        end

        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        chk("b_rst", b_addr, 32'hFFFF_FFF8);
        repeat (2) @(posedge clk);
        #1;
        chk("b_addr", b_addr, 32'h0);
        chk("b_pc", b_pc, 32'hFFFF_FFFC);
        chk("b_p4", b_p4, 32'h0);
        chk("b_cnt", b_cnt, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS pipeline: holds the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. It accepts stall and redirect (branch/jump) requests from later stages, detects misaligned redirect targets, and counts fetched instructions. The instruction memory is a combinational read port: data for `imem_addr` is valid in the same cycle.

## Interface

- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: hold PC and IF/ID contents this cycle.
- `redirect_valid` input 1: load `redirect_pc` into PC and flush IF/ID.
- `redirect_pc` input 32: redirect target byte address.
- `imem_addr` output 32: byte address to instruction memory; equals PC register.
- `imem_data` input 32: instruction word for `imem_addr`, same cycle.
- `id_valid` output 1: IF/ID holds a real instruction.
- `id_inst` output 32: captured instruction; 32'h0 (NOP) when invalid.
- `id_pc` output 32: address of `id_inst`.
- `id_pc_plus4` output 32: `id_pc` + 4, mod 2^32.
- `fetch_fault` output 1: fetch halted on misaligned redirect.
- `fault_pc` output 32: offending redirect address.
- `fetch_count` output 32: instructions delivered to IF/ID, wraps.

## Operation

- States: RUN, FAULT.
- Per-edge priority: `rst` > `redirect_valid` > FAULT hold > `stall` > normal fetch.
- Reset: PC=RESET_PC, state RUN, `id_valid`=0, `id_inst`=0, `id_pc`=0, `id_pc_plus4`=4, `fetch_fault`=0, `fault_pc`=0, `fetch_count`=0.
- Normal fetch (RUN, no stall, no redirect): `id_inst`<=`imem_data`, `id_pc`<=PC, `id_pc_plus4`<=PC+4, `id_valid`<=1, PC<=PC+4, `fetch_count`<=+1.
- Stall (RUN, no redirect): PC, IF/ID, `fetch_count` unchanged.
- Redirect, aligned (`redirect_pc[1:0]`==0): PC<=`redirect_pc`; IF/ID flushed (`id_valid`<=0, `id_inst`<=0; `id_pc`/`id_pc_plus4` unchanged); state RUN; `fetch_fault`<=0. Overrides stall. No delay slot: instruction at old PC is discarded.
- Redirect, misaligned: PC<=`redirect_pc`, IF/ID flushed, state FAULT, `fetch_fault`<=1, `fault_pc`<=`redirect_pc`.
- FAULT: no fetch; `id_valid` stays 0; `fetch_count` frozen; `stall` ignored; misaligned redirect updates `fault_pc` and stays FAULT; aligned redirect returns to RUN. `imem_addr` still shows PC (memory value ignored).
- Arithmetic: PC+4 and counter wrap mod 2^32 (0xFFFF_FFFC -> 0x0000_0000).

## Timing

- `imem_addr` is registered PC, combinational to memory; fetch latency one cycle: instruction at PC appears on `id_*` after the next rising edge.
- Redirect asserted in cycle n: `imem_addr`=target in n+1, first target instruction valid in IF/ID in n+2 (if not stalled).
- Stall is level-sensitive, one cycle per asserted cycle; no bubbles inserted on deassertion.
- Reset asserted mid-operation (including FAULT) overrides everything at that edge; outputs take reset values the following cycle.
- All outputs are registered except `imem_addr`, which is a direct register output.

## Structure

- Package `mips_fetch_pkg`: state enum (RUN, FAULT), `INST_NOP`=32'h0, `PC_STEP`=4.
- Sub-module `if_id_register`: valid/inst/pc/pc_plus4 flops with load, hold, and flush controls; the top holds the PC, FSM, fault capture, and counter.

## Test plan

- Reset with RESET_PC=0, memory words 0..3 = 0x11,0x22,0x33,0x44: `imem_addr`=0, `id_valid`=0; after 3 edges `id_inst`=0x33, `id_pc`=8, `id_pc_plus4`=12, `fetch_count`=3.
- Stall for 2 cycles after fetching 0x22: `id_inst` holds 0x22, `imem_addr` holds 8, count holds 2; on release the next edge gives 0x33.
- `redirect_valid`+`stall` together with `redirect_pc`=0x40: next cycle `imem_addr`=0x40, `id_valid`=0; following edge `id_pc`=0x40, `id_valid`=1.
- Redirect to 0x42: `fetch_fault`=1, `fault_pc`=0x42, `id_valid` stays 0, count frozen for 5 cycles; redirect to 0x80 clears the fault and 0x80 is fetched.
- RESET_PC=0xFFFF_FFF8: after 2 fetches `imem_addr`=0x0, and `id_pc_plus4` for 0xFFFF_FFFC equals 0.
- `rst` asserted while in FAULT: next cycle `fetch_fault`=0, `imem_addr`=RESET_PC, `fetch_count`=0.
